// File: rtl/sdram_lfsr_ctrl.sv
// sdram_lfsr_ctrl: SDRAM controller front-end with a behavioural word array.
// Stored words are XORed with a per-address Galois-LFSR key when the
// SCRAMBLE_EN macro is defined; without it the key is zero and the array
// holds plaintext, with identical port timing.
//
// state         | code | meaning
// INIT_WAIT     |  0   | power-up wait
// PRECHARGE_ALL |  1   | init precharge of all banks
// AUTO_REFRESH  |  2   | init refresh burst
// MODE_SET      |  3   | mode register load (init or reprogram)
// IDLE          |  4   | ready for a request
// ACTIVATE      |  5   | row open
// WRITE         |  6   | column write, array updated at its end
// READ          |  7   | column read command
// CAS_WAIT      |  8   | read latency, data returned at its end
// PRECHARGE     |  9   | row close
// REFRESH       | 10   | periodic auto-refresh
module sdram_lfsr_ctrl #(
    parameter int          DATA_W           = 32,
    parameter int          ADDR_W           = 23,
    parameter int          MEM_AW           = 10,
    parameter int          TRCD             = 2,
    parameter int          TRP              = 2,
    parameter int          TRFC             = 6,
    parameter int          CAS_LAT          = 2,
    parameter int          INIT_CYCLES      = 4,
    parameter int          INIT_REFRESH     = 8,
    parameter int          REFRESH_INTERVAL = 64,
    parameter logic [31:0] LFSR_TAPS        = 32'h80200003,
    parameter logic [31:0] LFSR_SEED        = 32'hACE1ACE1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_l,
    input  logic              mp_cs_l,
    input  logic              mp_wr_l,
    input  logic              mp_rd_l,
    input  logic              sdram_mode_set_l,
    input  logic [ADDR_W-1:0] mp_addx,
    input  logic [DATA_W-1:0] mp_data_in,
    output logic [DATA_W-1:0] mp_data_out,
    output logic              mp_data_valid,
    output logic              mp_busy,
    output logic [1:0]        sd_ba,
    output logic [3:0]        next_state
);

    typedef enum logic [3:0] {
        ST_INIT_WAIT     = 4'd0,
        ST_PRECHARGE_ALL = 4'd1,
        ST_AUTO_REFRESH  = 4'd2,
        ST_MODE_SET      = 4'd3,
        ST_IDLE          = 4'd4,
        ST_ACTIVATE      = 4'd5,
        ST_WRITE         = 4'd6,
        ST_READ          = 4'd7,
        ST_CAS_WAIT      = 4'd8,
        ST_PRECHARGE     = 4'd9,
        ST_REFRESH       = 4'd10
    } state_t;

    localparam logic [15:0] T_INIT    = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] T_RP      = 16'(TRP - 1);
    localparam logic [15:0] T_IREF    = 16'(INIT_REFRESH * TRFC - 1);
    localparam logic [15:0] T_RFC     = 16'(TRFC - 1);
    localparam logic [15:0] T_RCD     = 16'(TRCD - 1);
    localparam logic [15:0] T_CAS     = 16'(CAS_LAT - 1);
    localparam logic [15:0] RI_LAST   = 16'(REFRESH_INTERVAL - 1);

    state_t                r_state;
    logic [15:0]           r_timer;
    logic [15:0]           r_rcnt;
    logic                  r_pend;
    logic                  r_init_done;
    logic                  r_is_wr;
    logic [MEM_AW-1:0]     r_idx;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_dout;
    logic                  r_valid;
    logic [1:0]            r_ba;
    logic [DATA_W-1:0]     mem [0:(2**MEM_AW)-1];

    logic                  w_wrap;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_mode;
    logic                  w_tdone;
    logic [DATA_W-1:0]     w_key;
    logic                  w_unused_addr;

    // The refresh wrap is folded into busy one cycle early so that busy=0
    // always guarantees the next edge can accept a request.
    assign w_wrap   = r_init_done && (r_rcnt == RI_LAST);
    assign w_busy   = (r_state != ST_IDLE) || r_pend || w_wrap;
    assign w_accept = !w_busy && !mp_cs_l && (mp_wr_l ^ mp_rd_l) && sdram_mode_set_l;
    assign w_mode   = !w_busy && !sdram_mode_set_l;
    assign w_tdone  = (r_timer == 16'd0);
    assign w_unused_addr = ^mp_addx;

    // Per-address keystream: one Galois step from seed XOR word index.
`ifdef SCRAMBLE_EN
    localparam logic [DATA_W-1:0] SEED_W = DATA_W'(LFSR_SEED);
    localparam logic [DATA_W-1:0] TAPS_W = DATA_W'(LFSR_TAPS);
    logic [DATA_W-1:0] w_lfsr_s;
    always_comb begin
        w_lfsr_s = SEED_W ^ DATA_W'(r_idx);
        w_key    = (w_lfsr_s >> 1) ^ (w_lfsr_s[0] ? TAPS_W : '0);
    end
`else
    always_comb begin
        w_key = '0;
    end
`endif

    // Controller FSM, refresh scheduler and registered read port.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            r_state     <= ST_INIT_WAIT;
            r_timer     <= T_INIT;
            r_rcnt      <= 16'd0;
            r_pend      <= 1'b0;
            r_init_done <= 1'b0;
            r_is_wr     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_ba        <= 2'd0;
        end else begin
            r_valid <= 1'b0;
            if (r_init_done) begin
                r_rcnt <= w_wrap ? 16'd0 : r_rcnt + 16'd1;
            end
            if (w_wrap) begin
                r_pend <= 1'b1;
            end else if (r_state == ST_IDLE && r_pend) begin
                r_pend <= 1'b0;
            end
            case (r_state)
                ST_INIT_WAIT: begin
                    if (w_tdone) begin
                        r_state <= ST_PRECHARGE_ALL;
                        r_timer <= T_RP;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_PRECHARGE_ALL: begin
                    if (w_tdone) begin
                        r_state <= ST_AUTO_REFRESH;
                        r_timer <= T_IREF;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_AUTO_REFRESH: begin
                    if (w_tdone) begin
                        r_state <= ST_MODE_SET;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_MODE_SET: begin
                    r_state     <= ST_IDLE;
                    r_init_done <= 1'b1;
                end
                ST_IDLE: begin
                    if (r_pend) begin
                        r_state <= ST_REFRESH;
                        r_timer <= T_RFC;
                    end else if (w_mode) begin
                        r_state <= ST_MODE_SET;
                    end else if (w_accept) begin
                        r_state <= ST_ACTIVATE;
                        r_timer <= T_RCD;
                        r_is_wr <= !mp_wr_l;
                        r_idx   <= mp_addx[MEM_AW+1:2];
                        r_wdata <= mp_data_in;
                        r_ba    <= mp_addx[ADDR_W-1:ADDR_W-2];
                    end
                end
                ST_ACTIVATE: begin
                    if (w_tdone) begin
                        r_state <= r_is_wr ? ST_WRITE : ST_READ;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_PRECHARGE;
                    r_timer <= T_RP;
                end
                ST_READ: begin
                    r_state <= ST_CAS_WAIT;
                    r_timer <= T_CAS;
                end
                ST_CAS_WAIT: begin
                    if (w_tdone) begin
                        r_state <= ST_PRECHARGE;
                        r_timer <= T_RP;
                        r_valid <= 1'b1;
                        r_dout  <= mem[r_idx] ^ w_key;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_PRECHARGE, ST_REFRESH: begin
                    if (w_tdone) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_INIT_WAIT;
                    r_timer <= T_INIT;
                end
            endcase
        end
    end

    // Word array write at the end of WRITE; contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_l && r_state == ST_WRITE) begin
            mem[r_idx] <= r_wdata ^ w_key;
        end
    end

    assign mp_data_out   = r_dout;
    assign mp_data_valid = r_valid;
    assign mp_busy       = w_busy;
    assign sd_ba         = r_ba;
    assign next_state    = r_state;

endmodule

// File: tb/tb_sdram_lfsr_ctrl.sv
// Testbench for sdram_lfsr_ctrl: directed sequence plus random traffic,
// checked against a plaintext word model indexed by (addr/4) mod 1024.
module tb_sdram_lfsr_ctrl;

    localparam int INIT_END  = 4 + 2 + 8 * 6 + 1;
    localparam int TRFC      = 6;
    localparam int REF_INT   = 64;

    logic        sys_clk = 1'b0;
    logic        sys_rst_l;
    logic        mp_cs_l;
    logic        mp_wr_l;
    logic        mp_rd_l;
    logic        sdram_mode_set_l;
    logic [22:0] mp_addx;
    logic [31:0] mp_data_in;
    logic [31:0] mp_data_out;
    logic        mp_data_valid;
    logic        mp_busy;
    logic [1:0]  sd_ba;
    logic [3:0]  next_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [0:1023];
    int unsigned written_q[$];

    always #5 sys_clk = ~sys_clk;

    sdram_lfsr_ctrl uut (
        .sys_clk         (sys_clk),
        .sys_rst_l       (sys_rst_l),
        .mp_cs_l         (mp_cs_l),
        .mp_wr_l         (mp_wr_l),
        .mp_rd_l         (mp_rd_l),
        .sdram_mode_set_l(sdram_mode_set_l),
        .mp_addx         (mp_addx),
        .mp_data_in      (mp_data_in),
        .mp_data_out     (mp_data_out),
        .mp_data_valid   (mp_data_valid),
        .mp_busy         (mp_busy),
        .sd_ba           (sd_ba),
        .next_state      (next_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [31:0] key_of(input int unsigned w);
`ifdef SCRAMBLE_EN
        logic [31:0] s;
        s = 32'hACE1ACE1 ^ w;
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
`else
        return 32'h0 + 32'(w & 0);
`endif
    endfunction

    function automatic int exp_init_state(input int k);
        if (k < 4) return 0;
        if (k < 6) return 1;
        if (k < 54) return 2;
        if (k < 55) return 3;
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mp_cs_l = 1'b1;
        mp_wr_l = 1'b1;
        mp_rd_l = 1'b1;
        sdram_mode_set_l = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (mp_busy !== 1'b0 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, 64'(n < 400), 64'd1);
    endtask

    task automatic do_op(input bit is_wr, input logic [22:0] addr,
                         input logic [31:0] data, input bit chk_fall);
        int unsigned w;
        logic [31:0] expv;
        w = (int'(addr) / 4) % 1024;
        wait_ready("ready");
        mp_cs_l    = 1'b0;
        mp_wr_l    = !is_wr;
        mp_rd_l    = is_wr;
        mp_addx    = addr;
        mp_data_in = data;
        @(negedge sys_clk);
        idle_inputs();
        chk("busy_rise", 64'(mp_busy), 64'd1);
        chk("activate", 64'(next_state), 64'd5);
        chk("sd_ba", 64'(sd_ba), 64'((addr >> 21) & 23'h3));
        if (is_wr) begin
            @(negedge sys_clk);
            chk("act_hold", 64'(next_state), 64'd5);
            @(negedge sys_clk);
            chk("write_st", 64'(next_state), 64'd6);
            @(negedge sys_clk);
            chk("mem_write", 64'(uut.mem[w]), 64'(data ^ key_of(w)));
            chk("prech_st", 64'(next_state), 64'd9);
            model_mem[w] = data;
            written_q.push_back(w);
            @(negedge sys_clk);
            @(negedge sys_clk);
            chk("wr_idle", 64'(next_state), 64'd4);
            if (chk_fall) chk("busy_fall", 64'(mp_busy), 64'd0);
        end else begin
            expv = model_mem[w];
            repeat (4) begin
                @(negedge sys_clk);
                chk("valid_early", 64'(mp_data_valid), 64'd0);
            end
            @(negedge sys_clk);
            chk("valid_pulse", 64'(mp_data_valid), 64'd1);
            chk("rd_data", 64'(mp_data_out), 64'(expv));
            @(negedge sys_clk);
            chk("valid_end", 64'(mp_data_valid), 64'd0);
            chk("rd_hold", 64'(mp_data_out), 64'(expv));
            @(negedge sys_clk);
            chk("rd_idle", 64'(next_state), 64'd4);
        end
    endtask

    initial begin
        int n;
        int unsigned w;
        logic [22:0] a;
        logic [31:0] d;
        logic [22:0] rd_order [9];

        idle_inputs();
        sys_rst_l  = 1'b0;
        mp_addx    = '0;
        mp_data_in = '0;

        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_state", 64'(next_state), 64'd0);
        chk("rst_busy", 64'(mp_busy), 64'd1);
        chk("rst_valid", 64'(mp_data_valid), 64'd0);
        chk("rst_dout", 64'(mp_data_out), 64'd0);
        chk("rst_ba", 64'(sd_ba), 64'd0);

        // Init walk
        sys_rst_l = 1'b1;
        for (int k = 1; k <= INIT_END; k++) begin
            @(negedge sys_clk);
            chk("init_state", 64'(next_state), 64'(exp_init_state(k)));
            chk("init_busy", 64'(mp_busy), 64'(k < INIT_END));
        end

        // Basic write/read at 0x0
        do_op(1'b1, 23'h0, 32'h22222222, 1'b1);
        do_op(1'b0, 23'h0, 32'h0, 1'b0);
`ifdef SCRAMBLE_EN
        chk("ciphertext", 64'(uut.mem[0] !== 32'h22222222), 64'd1);
`else
        chk("plaintext", 64'(uut.mem[0]), 64'h22222222);
`endif

        // Fill 0x4..0x20, read back in mixed order
        for (int i = 0; i < 8; i++) begin
            d = 32'h11111111 * 32'(((i + 2) % 9) + 1);
            do_op(1'b1, 23'(4 * (i + 1)), d, 1'b0);
        end
        rd_order = '{23'h0, 23'h4, 23'h8, 23'hc, 23'h10, 23'h14, 23'h1c, 23'h18, 23'h20};
        for (int i = 0; i < 9; i++) do_op(1'b0, rd_order[i], 32'h0, 1'b0);
        chk("model_8", 64'(model_mem[2]), 64'h44444444);

        // Write held over the refresh wrap
        wait_ready("ref_ready");
        n = 0;
        while (next_state !== 4'd10 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        chk("ref_seen", 64'(n < 300), 64'd1);
        repeat (REF_INT - 2) @(negedge sys_clk);
        mp_cs_l    = 1'b0;
        mp_wr_l    = 1'b0;
        mp_addx    = 23'h24;
        mp_data_in = 32'h5A5A5A5A;
        @(negedge sys_clk);
        chk("ref_first_idle", 64'(next_state), 64'd4);
        for (int k = 0; k < TRFC; k++) begin
            @(negedge sys_clk);
            chk("ref_state", 64'(next_state), 64'd10);
        end
        @(negedge sys_clk);
        chk("ref_back_idle", 64'(next_state), 64'd4);
        @(negedge sys_clk);
        chk("ref_then_act", 64'(next_state), 64'd5);
        idle_inputs();
        model_mem[9] = 32'h5A5A5A5A;
        wait_ready("ref_wr_done");
        chk("ref_wr_mem", 64'(uut.mem[9]), 64'(32'h5A5A5A5A ^ key_of(9)));
        do_op(1'b0, 23'h24, 32'h0, 1'b0);

        // Reset during ACTIVATE of a write to 0x8
        wait_ready("rst_wr_ready");
        mp_cs_l    = 1'b0;
        mp_wr_l    = 1'b0;
        mp_addx    = 23'h8;
        mp_data_in = 32'hDEADBEEF;
        @(negedge sys_clk);
        idle_inputs();
        chk("rst_wr_act", 64'(next_state), 64'd5);
        sys_rst_l = 1'b0;
        @(negedge sys_clk);
        chk("midrst_state", 64'(next_state), 64'd0);
        chk("midrst_dout", 64'(mp_data_out), 64'd0);
        repeat (3) begin
            @(negedge sys_clk);
            chk("midrst_valid", 64'(mp_data_valid), 64'd0);
        end
        sys_rst_l = 1'b1;
        wait_ready("reinit");
        chk("dropped_wr", 64'(uut.mem[2]), 64'(32'h44444444 ^ key_of(2)));
        do_op(1'b0, 23'h8, 32'h0, 1'b0);

        // Reset during CAS_WAIT suppresses the valid pulse
        wait_ready("rst_rd_ready");
        mp_cs_l = 1'b0;
        mp_rd_l = 1'b0;
        mp_addx = 23'h8;
        @(negedge sys_clk);
        idle_inputs();
        repeat (3) @(negedge sys_clk);
        sys_rst_l = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            chk("rd_rst_valid", 64'(mp_data_valid), 64'd0);
        end
        sys_rst_l = 1'b1;
        wait_ready("reinit2");

        // Double strobe, cs high, and mode reprogram with a concurrent request
        wait_ready("dbl_ready");
        mp_cs_l    = 1'b0;
        mp_wr_l    = 1'b0;
        mp_rd_l    = 1'b0;
        mp_addx    = 23'h8;
        mp_data_in = 32'hBADBAD00;
        @(negedge sys_clk);
        idle_inputs();
        chk("dbl_ignored", 64'(next_state), 64'd4);
        wait_ready("cs_ready");
        mp_wr_l = 1'b0;
        @(negedge sys_clk);
        idle_inputs();
        chk("cs_ignored", 64'(next_state), 64'd4);
        wait_ready("mode_ready");
        sdram_mode_set_l = 1'b0;
        mp_cs_l          = 1'b0;
        mp_wr_l          = 1'b0;
        mp_addx          = 23'hc;
        @(negedge sys_clk);
        idle_inputs();
        chk("mode_set", 64'(next_state), 64'd3);
        @(negedge sys_clk);
        chk("mode_done", 64'(next_state), 64'd4);
        chk("mem8_kept", 64'(uut.mem[2]), 64'(32'h44444444 ^ key_of(2)));
        chk("memc_kept", 64'(uut.mem[3]), 64'(model_mem[3] ^ key_of(3)));
        do_op(1'b0, 23'h8, 32'h0, 1'b0);
        do_op(1'b0, 23'hc, 32'h0, 1'b0);

        // Random traffic with wrapped and banked addresses
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 23'($urandom);
                d = $urandom;
                do_op(1'b1, a, d, 1'b0);
            end else begin
                w = written_q[$urandom_range(0, written_q.size() - 1)];
                a = 23'(($urandom % 2048) * 4096 + w * 4 + ($urandom % 4));
                do_op(1'b0, a, 32'h0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
